// File: rtl/f_pc_predictor_if.sv
// Fetch/decode PC-control bundle between the pipeline and the F-stage PC predictor.
// The predictor takes the slave modport; the pipeline side takes master.
interface f_pc_predictor_if;
   logic        stall;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic [31:0] f_pred_target;
   logic        d_valid;
   logic [31:0] d_pc;
   logic        d_is_branch;
   logic        d_taken;
   logic [31:0] d_target;
   logic        d_pred_taken;
   logic [31:0] d_pred_target;
   logic        redirect;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;

   modport master (
      output stall, d_valid, d_pc, d_is_branch, d_taken, d_target,
             d_pred_taken, d_pred_target, exc_req, eret_req, epc,
      input  f_pc, f_pred_taken, f_pred_target, redirect
   );

   modport slave (
      input  stall, d_valid, d_pc, d_is_branch, d_taken, d_target,
             d_pred_taken, d_pred_target, exc_req, eret_req, epc,
      output f_pc, f_pred_taken, f_pred_target, redirect
   );
endinterface

// File: rtl/f_pc_predictor.sv
// F-stage PC register with a direct-mapped BTB; D-stage resolution corrects mispredictions.
// Define NPC_BHT_EN to add a 2-bit saturating direction counter per BTB entry.
module f_pc_predictor #(
   parameter int unsigned BTB_DEPTH   = 16,
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [31:0] EXC_HANDLER = 32'h0000_4180
) (
   input  logic             clk,
   input  logic             reset,
   f_pc_predictor_if.slave  bus
);

   localparam int unsigned IDX   = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = 30 - IDX;

   logic [31:0]          pc_q;
   logic [31:0]          next_pc;
   logic [31:0]          correct_pc;
   logic                 mispredict;
   logic                 btb_we;

   logic [BTB_DEPTH-1:0] btb_valid;
   logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
   logic [31:0]          btb_target [BTB_DEPTH];
`ifdef NPC_BHT_EN
   logic [1:0]           btb_cnt    [BTB_DEPTH];
`endif

   logic [IDX-1:0]       f_idx, d_idx;
   logic [TAG_W-1:0]     f_tag, d_tag;
   logic                 f_hit, d_hit;

   assign f_idx = pc_q[IDX+1:2];
   assign f_tag = pc_q[31:IDX+2];
   assign d_idx = bus.d_pc[IDX+1:2];
   assign d_tag = bus.d_pc[31:IDX+2];

   // Lookup reads the array directly, so a same-cycle D write is seen only next cycle.
   assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign d_hit = btb_valid[d_idx] && (btb_tag[d_idx] == d_tag);

`ifdef NPC_BHT_EN
   assign bus.f_pred_taken = f_hit && btb_cnt[f_idx][1];
`else
   assign bus.f_pred_taken = f_hit;
`endif
   assign bus.f_pred_target = bus.f_pred_taken ? btb_target[f_idx] : '0;
   assign bus.f_pc          = pc_q;

   assign correct_pc   = bus.d_taken ? bus.d_target : bus.d_pc + 32'd4;
   assign mispredict   = bus.d_valid &&
                         ((bus.d_taken != bus.d_pred_taken) ||
                          (bus.d_taken && (bus.d_target != bus.d_pred_target)));
   assign bus.redirect = mispredict && !bus.exc_req && !bus.eret_req;
   assign btb_we       = bus.d_valid && !bus.exc_req && !bus.eret_req;

   always_comb begin
      next_pc = pc_q + 32'd4;
      if (bus.exc_req)           next_pc = EXC_HANDLER;
      else if (bus.eret_req)     next_pc = bus.epc;
      else if (bus.redirect)     next_pc = correct_pc;
      else if (bus.stall)        next_pc = pc_q;
      else if (bus.f_pred_taken) next_pc = bus.f_pred_target;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= next_pc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btb_valid <= '0;
         for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
`ifdef NPC_BHT_EN
            btb_cnt[i]    <= 2'b01;
`endif
         end
      end else if (btb_we) begin
         if (bus.d_is_branch) begin
            if (d_hit) begin
               if (bus.d_taken) btb_target[d_idx] <= bus.d_target;
`ifdef NPC_BHT_EN
               if (bus.d_taken) begin
                  if (btb_cnt[d_idx] != 2'b11) btb_cnt[d_idx] <= btb_cnt[d_idx] + 2'd1;
               end else begin
                  if (btb_cnt[d_idx] != 2'b00) btb_cnt[d_idx] <= btb_cnt[d_idx] - 2'd1;
               end
`else
               if (!bus.d_taken) btb_valid[d_idx] <= 1'b0;
`endif
            end else if (bus.d_taken) begin
               btb_valid[d_idx]  <= 1'b1;
               btb_tag[d_idx]    <= d_tag;
               btb_target[d_idx] <= bus.d_target;
`ifdef NPC_BHT_EN
               btb_cnt[d_idx]    <= 2'b10;
`endif
            end
         end else if (bus.d_pred_taken) begin
            // A non-branch predicted taken means the entry at this index is stale.
            btb_valid[d_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_f_pc_predictor.sv
// Directed-vector bench for f_pc_predictor; expectations adapt to NPC_BHT_EN.
module tb_f_pc_predictor;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

`ifdef NPC_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif

   f_pc_predictor_if bus ();

   f_pc_predictor #(
      .BTB_DEPTH   (16),
      .RESET_PC    (32'h0000_3000),
      .EXC_HANDLER (32'h0000_4180)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      bus.d_valid       = 1'b0;
      bus.d_pc          = '0;
      bus.d_is_branch   = 1'b0;
      bus.d_taken       = 1'b0;
      bus.d_target      = '0;
      bus.d_pred_taken  = 1'b0;
      bus.d_pred_target = '0;
   endtask

   task automatic drive_d(input logic [31:0] pc, input logic br, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      bus.d_valid       = 1'b1;
      bus.d_pc          = pc;
      bus.d_is_branch   = br;
      bus.d_taken       = tk;
      bus.d_target      = tgt;
      bus.d_pred_taken  = ptk;
      bus.d_pred_target = ptgt;
   endtask

   task automatic do_eret(input logic [31:0] addr);
      bus.eret_req = 1'b1;
      bus.epc      = addr;
      tick();
      bus.eret_req = 1'b0;
      bus.epc      = '0;
      #1;
   endtask

   task automatic chk_pc(input string name, input logic [31:0] exp);
      n_vec++;
      if (bus.f_pc !== exp) begin
         n_err++;
         $display("FAIL %s: f_pc=%h expected %h", name, bus.f_pc, exp);
      end
   endtask

   task automatic chk_pred(input string name, input logic exp_t, input logic [31:0] exp_tgt);
      n_vec++;
      if (bus.f_pred_taken !== exp_t || bus.f_pred_target !== exp_tgt) begin
         n_err++;
         $display("FAIL %s: pred=%b/%h expected %b/%h", name,
                  bus.f_pred_taken, bus.f_pred_target, exp_t, exp_tgt);
      end
   endtask

   task automatic chk_redir(input string name, input logic exp);
      n_vec++;
      if (bus.redirect !== exp) begin
         n_err++;
         $display("FAIL %s: redirect=%b expected %b", name, bus.redirect, exp);
      end
   endtask

   task automatic test_reset();
      chk_pc("reset_initial", 32'h3000);
      tick(); chk_pc("reset_seq1", 32'h3004);
      tick(); chk_pc("reset_seq2", 32'h3008);
      #3 reset = 1'b1;
      #1;
      chk_pc("reset_async", 32'h3000);
      chk_redir("reset_redirect", 1'b0);
      chk_pred("reset_pred", 1'b0, 32'h0);
      tick();
      reset = 1'b0;
      chk_pc("reset_release", 32'h3000);
      tick(); chk_pc("reset_run1", 32'h3004);
      tick(); chk_pc("reset_run2", 32'h3008);
   endtask

   task automatic test_train();
      drive_d(32'h3010, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0);
      #1 chk_redir("train_redirect", 1'b1);
      tick(); clear_d();
      chk_pc("train_target", 32'h3040);
      do_eret(32'h3010);
      chk_pc("train_refetch", 32'h3010);
      chk_pred("train_pred", 1'b1, 32'h3040);
      tick(); chk_pc("train_follow", 32'h3040);
   endtask

   task automatic test_not_taken();
      drive_d(32'h3010, 1'b1, 1'b1, 32'h3040, 1'b1, 32'h3040);
      #1 chk_redir("nt_correct_redirect", 1'b0);
      tick(); clear_d();
      chk_pc("nt_correct_seq", 32'h3044);
      drive_d(32'h3010, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3040);
      #1 chk_redir("nt_redirect", 1'b1);
      tick(); clear_d();
      chk_pc("nt_fallthrough", 32'h3014);
      do_eret(32'h3010);
      chk_pred("nt_pred_after1", BHT, BHT ? 32'h3040 : 32'h0);
      // second not-taken resolves while F looks up the same index: old contents seen
      drive_d(32'h3010, 1'b1, 1'b0, 32'h0, BHT, BHT ? 32'h3040 : 32'h0);
      #1 chk_redir("nt2_redirect", BHT);
      chk_pred("nt2_same_cycle", BHT, BHT ? 32'h3040 : 32'h0);
      tick(); clear_d();
      chk_pc("nt2_next", 32'h3014);
      do_eret(32'h3010);
      chk_pred("nt_pred_after2", 1'b0, 32'h0);
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      drive_d(32'h3100, 1'b1, 1'b1, 32'h3200, 1'b0, 32'h0);
      #1 chk_redir("stall_redirect", 1'b1);
      tick(); clear_d();
      chk_pc("stall_redirect_wins", 32'h3200);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_pc("stall_hold", 32'h3200);
      end
      bus.stall = 1'b0;
      tick(); chk_pc("stall_release", 32'h3204);
   endtask

   task automatic test_exc();
      bus.exc_req  = 1'b1;
      bus.eret_req = 1'b1;
      bus.epc      = 32'h5000;
      drive_d(32'h3030, 1'b1, 1'b1, 32'h3300, 1'b0, 32'h0);
      #1 chk_redir("exc_redirect", 1'b0);
      tick(); clear_d();
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      bus.epc      = '0;
      chk_pc("exc_handler", 32'h4180);
      do_eret(32'h3030);
      chk_pc("exc_eret", 32'h3030);
      chk_pred("exc_btb_unchanged", 1'b0, 32'h0);
   endtask

   task automatic test_alias();
      drive_d(32'h3020, 1'b1, 1'b1, 32'h3060, 1'b0, 32'h0);
      tick(); clear_d();
      chk_pc("alias_train", 32'h3060);
      do_eret(32'h3020);
      chk_pred("alias_trained", 1'b1, 32'h3060);
      drive_d(32'h3020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3060);
      #1 chk_redir("alias_redirect", 1'b1);
      tick(); clear_d();
      chk_pc("alias_fallthrough", 32'h3024);
      do_eret(32'h3020);
      chk_pred("alias_invalid", 1'b0, 32'h0);
   endtask

   task automatic test_boundary();
      do_eret(32'hFFFF_FFFC);
      chk_pc("wrap_top", 32'hFFFF_FFFC);
      tick(); chk_pc("wrap_zero", 32'h0);
      drive_d(32'h3008, 1'b1, 1'b1, 32'h3043, 1'b0, 32'h0);
      tick(); clear_d();
      chk_pc("unaligned_target", 32'h3043);
      do_eret(32'h3008);
      chk_pred("unaligned_stored", 1'b1, 32'h3043);
   endtask

   task automatic test_reset_btb();
      do_eret(32'h3100);
      chk_pred("btb_before_reset", 1'b1, 32'h3200);
      #3 reset = 1'b1;
      #1 chk_pc("btb_reset_pc", 32'h3000);
      tick();
      reset = 1'b0;
      do_eret(32'h3100);
      chk_pred("btb_after_reset", 1'b0, 32'h0);
   endtask

   initial begin
      reset        = 1'b1;
      bus.stall    = 1'b0;
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      bus.epc      = '0;
      clear_d();
      repeat (2) tick();
      reset = 1'b0;
      test_reset();
      test_train();
      test_not_taken();
      test_stall();
      test_exc();
      test_alias();
      test_boundary();
      test_reset_btb();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
